// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive path and its synchronizers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int unsigned UART_SYNC_STAGES   = 2;
    localparam int unsigned UART_MAX_DATA_BITS = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer with configurable asynchronous reset value (rx, cts).
module uart_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: start detect, 2-of-3 vote, framing, one-entry holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic RST_LINE_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       rx,
    input  logic       cfg_data8,
`ifdef UART_RX_PARITY_EN
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    output logic       rx_parity_err,
`endif
    input  logic       baud_sample_6th,
    input  logic       baud_sample_8th,
    input  logic       baud_sample_10th,
    input  logic       baud_sample_16th,
    output logic       baud_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       rx_overrun_clr
);

    uart_rx_state_t state_q, state_d;
    logic                        rx_s;
    logic [UART_SYNC_STAGES-1:0] arm_q, arm_d;
    logic                        rx_prev_q, rx_prev_d;
    logic                        v6_q, v6_d, v8_q, v8_d;
    logic                        data8_q, data8_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [UART_MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                        baud_clear_q, baud_clear_d;
    logic [7:0]                  rx_data_q, rx_data_d;
    logic                        rx_valid_q, rx_valid_d;
    logic                        rx_frame_err_q, rx_frame_err_d;
    logic                        rx_overrun_q, rx_overrun_d;
    logic                        fall, bit_v, commit;
    logic                        tick6, tick8, tick10, tick16;
`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d;
    logic rx_parity_err_q, rx_parity_err_d;
`endif

    uart_sync #(
        .STAGES (UART_SYNC_STAGES),
        .RST_VAL(RST_LINE_VAL)
    ) u_sync (
        .clk  (clk),
        .rst_b(rst_b),
        .d    (rx),
        .q    (rx_s)
    );

    // Edge detect stays disarmed until the synchronizer has flushed its reset
    // value, so a line already held low out of reset cannot fake a start edge.
    assign arm_d     = {arm_q[UART_SYNC_STAGES-2:0], 1'b1};
    assign rx_prev_d = arm_q[UART_SYNC_STAGES-1] & rx_s;
    assign fall      = rx_prev_q & ~rx_s;

    // Ticks in the clear cycle belong to the generator's stale count.
    assign tick6  = baud_sample_6th  & ~baud_clear_q;
    assign tick8  = baud_sample_8th  & ~baud_clear_q;
    assign tick10 = baud_sample_10th & ~baud_clear_q;
    assign tick16 = baud_sample_16th & ~baud_clear_q;

    assign v6_d  = tick6 ? rx_s : v6_q;
    assign v8_d  = tick8 ? rx_s : v8_q;
    assign bit_v = maj3(v6_q, v8_q, rx_s);

    always_comb begin
        state_d      = state_q;
        data8_d      = data8_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        baud_clear_d = 1'b0;
        commit       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    baud_clear_d = 1'b1;
                    data8_d      = cfg_data8;
                    bit_cnt_d    = '0;
                    shift_d      = '0;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = cfg_parity_en;
                    par_odd_d = cfg_parity_odd;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (tick10 && bit_v) begin
                    state_d = IDLE;
                end else if (tick16) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick10) begin
                    shift_d[bit_cnt_q[2:0]] = bit_v;
                end
                if (tick16) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == (data8_q ? 4'd7 : 4'd6)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick10) begin
                    par_bit_d = bit_v;
                end
                if (tick16) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick10) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_data_d      = commit ? shift_q : rx_data_q;
        rx_frame_err_d = commit ? ~bit_v  : rx_frame_err_q;
        rx_valid_d     = rx_valid_q;
        if (commit) begin
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        rx_overrun_d = rx_overrun_q;
        if (commit && rx_valid_q && !rx_ready) begin
            rx_overrun_d = 1'b1;
        end else if (rx_overrun_clr) begin
            rx_overrun_d = 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        rx_parity_err_d = rx_parity_err_q;
        if (commit) begin
            rx_parity_err_d = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            arm_q          <= '0;
            rx_prev_q      <= 1'b0;
            v6_q           <= 1'b0;
            v8_q           <= 1'b0;
            data8_q        <= 1'b1;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            baud_clear_q   <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            arm_q          <= arm_d;
            rx_prev_q      <= rx_prev_d;
            v6_q           <= v6_d;
            v8_q           <= v8_d;
            data8_q        <= data8_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            baud_clear_q   <= baud_clear_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            par_bit_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
        end else begin
            par_en_q        <= par_en_d;
            par_odd_q       <= par_odd_d;
            par_bit_q       <= par_bit_d;
            rx_parity_err_q <= rx_parity_err_d;
        end
    end

    assign rx_parity_err = rx_parity_err_q;
`endif

    assign baud_clear   = baud_clear_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a simple 16x-oversampling baud tick model.
module tb_uart_rx;

    localparam int P   = 4;
    localparam int BIT = 16 * P;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       rx;
    logic       cfg_data8;
    logic       t6 = 1'b0, t8 = 1'b0, t10 = 1'b0, t16 = 1'b0;
    logic       baud_clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_overrun_clr;
`ifdef UART_RX_PARITY_EN
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       rx_parity_err;
`endif

    int total = 0;
    int bad = 0;
    int clr_cnt = 0;
    int acc_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    int cyc = 0;
    int last10 = -100;
    int rise_gap = -1;
    int div = 0;
    int smp = 0;
    logic valid_prev = 1'b0;

    uart_rx #(.RST_LINE_VAL(1'b1)) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .rx              (rx),
        .cfg_data8       (cfg_data8),
`ifdef UART_RX_PARITY_EN
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_odd  (cfg_parity_odd),
        .rx_parity_err   (rx_parity_err),
`endif
        .baud_sample_6th (t6),
        .baud_sample_8th (t8),
        .baud_sample_10th(t10),
        .baud_sample_16th(t16),
        .baud_clear      (baud_clear),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_frame_err    (rx_frame_err),
        .rx_overrun      (rx_overrun),
        .rx_overrun_clr  (rx_overrun_clr)
    );

    always #5 clk = ~clk;

    // Baud generator model plus event monitors, all updated on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rx_valid && !valid_prev) rise_gap = cyc - last10;
        valid_prev = rx_valid;
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            acc_data = rx_data;
        end
        t6 = 1'b0; t8 = 1'b0; t10 = 1'b0; t16 = 1'b0;
        if (baud_clear) begin
            clr_cnt++;
            div = 0;
            smp = 0;
        end else begin
            div++;
            if (div == P) begin
                div = 0;
                smp = (smp == 16) ? 1 : smp + 1;
                t6  = (smp == 6);
                t8  = (smp == 8);
                t10 = (smp == 10);
                t16 = (smp == 16);
            end
        end
        if (t10) last10 = cyc;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic with_par,
                              input logic par, input logic stop, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (with_par) send_bit(par);
        send_bit(stop);
        rx = 1'b1;
        idle(gap);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; rx = 1'b1; cfg_data8 = 1'b1; rx_ready = 1'b0; rx_overrun_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
`endif
        idle(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", rx_frame_err); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", rx_overrun); end
        total++; if (baud_clear !== 1'b0) begin bad++; $display("FAIL reset_clr got=%b want=0", baud_clear); end
        rst_b = 1'b1;
        idle(BIT);
    endtask

    task automatic test_8n1();
        int c0;
        c0 = clr_cnt;
        rise_gap = -1;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, BIT);
        total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL 8n1_data got=%h want=55", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL 8n1_valid got=%b want=1", rx_valid); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL 8n1_ferr got=%b want=0", rx_frame_err); end
        total++; if (clr_cnt - c0 !== 1) begin bad++; $display("FAIL 8n1_clr_pulses got=%0d want=1", clr_cnt - c0); end
        total++; if (rise_gap !== 1) begin bad++; $display("FAIL 8n1_valid_latency got=%0d want=1", rise_gap); end
        drain();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL 8n1_accept got=%b want=0", rx_valid); end
    endtask

    task automatic test_7bit();
        cfg_data8 = 1'b0;
        send_frame(8'h7F, 7, 1'b0, 1'b0, 1'b1, BIT);
        cfg_data8 = 1'b1;
        total++; if (rx_data !== 8'h7F) begin bad++; $display("FAIL 7bit_data got=%h want=7f", rx_data); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL 7bit_ferr got=%b want=0", rx_frame_err); end
        drain();
    endtask

    task automatic test_glitch();
        int c0;
        c0 = clr_cnt;
        rx = 1'b0;
        idle(3 * P);
        rx = 1'b1;
        idle(4 * BIT);
        total++; if (clr_cnt - c0 !== 1) begin bad++; $display("FAIL glitch_clr got=%0d want=1", clr_cnt - c0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", rx_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, BIT);
        total++; if (rx_data !== 8'hA3) begin bad++; $display("FAIL ferr_data got=%h want=a3", rx_data); end
        total++; if (rx_frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b want=1", rx_frame_err); end
        drain();
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, BIT);
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", rx_overrun); end
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, BIT);
        total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL ovr_data got=%h want=22", rx_data); end
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", rx_overrun); end
        rx_overrun_clr = 1'b1;
        @(negedge clk);
        rx_overrun_clr = 1'b0;
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", rx_overrun); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held got=%b want=1", rx_valid); end
        drain();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = acc_cnt;
        rx_ready = 1'b1;
        send_frame(8'hC6, 8, 1'b0, 1'b0, 1'b1, 0);
        total++; if (acc_data !== 8'hC6) begin bad++; $display("FAIL b2b_first got=%h want=c6", acc_data); end
        send_frame(8'h39, 8, 1'b0, 1'b0, 1'b1, BIT);
        rx_ready = 1'b0;
        total++; if (acc_data !== 8'h39) begin bad++; $display("FAIL b2b_second got=%h want=39", acc_data); end
        total++; if (acc_cnt - a0 !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", acc_cnt - a0); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", rx_overrun); end
    endtask

    task automatic test_reset_midframe();
        int c0;
        rx = 1'b0;
        idle(3 * BIT);
        rst_b = 1'b0;
        idle(5);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", rx_valid); end
        c0 = clr_cnt;
        rst_b = 1'b1;
        idle(4 * BIT);
        total++; if (clr_cnt - c0 !== 0) begin bad++; $display("FAIL mid_rst_low_line got=%0d want=0", clr_cnt - c0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_byte got=%b want=0", rx_valid); end
        rx = 1'b1;
        idle(BIT);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, BIT);
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL mid_rst_recover got=%h want=5a", rx_data); end
        drain();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, BIT);
        total++; if (rx_parity_err !== 1'b1) begin bad++; $display("FAIL par_bad got=%b want=1", rx_parity_err); end
        drain();
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, BIT);
        total++; if (rx_parity_err !== 1'b0) begin bad++; $display("FAIL par_good got=%b want=0", rx_parity_err); end
        total++; if (rx_data !== 8'h03) begin bad++; $display("FAIL par_data got=%h want=03", rx_data); end
        drain();
        cfg_parity_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_7bit();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
